instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Synthesizable instruction-fetch front end. It sits directly upstream of the CPU decode/execute sequencer.
- Owns the PC and drives read requests to large_ram (fixed 1-cycle read latency).
- Buffers fetched words in a small FIFO and hands {instr, pc} to execute over a valid/ready handshake.
- Execute returns control flow (jump, skip, halt) through a single redirect port.

Parameters:
- ADDR_WIDTH, 12, memory address / PC width.
- DATA_WIDTH, 16, instruction word width.
- RESET_PC, 'h100, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; legal values are 2 to 8.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  fetch enable; when low, no new reads are issued.
- mem_addr  output  ADDR_WIDTH  registered read address to RAM.
- mem_rd_en  output  1  registered read strobe; RAM samples it at the next posedge.
- mem_rdata  input  DATA_WIDTH  RAM read data; valid in the cycle after the request was sampled.
- instr  output  DATA_WIDTH  FIFO head instruction.
- instr_pc  output  ADDR_WIDTH  address the head instruction was fetched from.
- instr_valid  output  1  FIFO non-empty.
- instr_ready  input  1  execute accepts the head; a transfer occurs when valid and ready are both high.
- redirect_valid  input  1  single-cycle control-flow change.
- redirect_pc  input  ADDR_WIDTH  new fetch address; bit 0 is forced to 0.

Behaviour:
- Reset (asynchronous, any time, including mid-fetch):
  - pc=RESET_PC, mem_addr=RESET_PC, mem_rd_en=0.
  - FIFO count=0, instr_valid=0, instr=0, instr_pc=0.
  - Read pipeline flags p0=p1=0.
  - Outstanding RAM data is never captured.
- Read pipeline:
  - p0 mirrors mem_rd_en (request on bus this cycle).
  - At each posedge, p1<=p0. When p1=1, mem_rdata is pushed into the FIFO along with its tagged address.
  - The tag address travels in a 2-deep pipeline alongside p0/p1.
- Issue rule, evaluated each posedge when no redirect is active:
  - pop = instr_valid & instr_ready.
  - occ = count + p0 + p1 - pop.
  - If run & (occ < FIFO_DEPTH): mem_rd_en<=1, mem_addr<=pc, pc<=pc+2.
  - Otherwise mem_rd_en<=0 and pc holds.
- PC arithmetic is modulo 2^ADDR_WIDTH; 'hFFE+2 wraps to 'h000.
- Throughput: one instruction per cycle sustained when run=1 and instr_ready=1.
- Latency: with run high, a request appears at edge E1, data is on the bus after E2, and instr_valid is high after E3. This holds after reset, after run rises, and after a redirect edge.
- Backpressure:
  - The credit rule guarantees the FIFO never overflows. Every returning word has a slot.
  - Reads stop when occ = FIFO_DEPTH.
- FIFO:
  - Strict in-order.
  - Push and pop in the same cycle are both honoured, with count unchanged.
  - Pop on empty is impossible, since valid=0.
  - When empty, instr and instr_pc are don't-care (except 0 immediately after reset).
- Redirect (priority over everything except reset), at the posedge where redirect_valid=1:
  - FIFO flushed (count=0).
  - p0=p1=0, so in-flight data is dropped, including a word returning that same edge.
  - mem_rd_en<=0, pc<={redirect_pc[ADDR_WIDTH-1:1],1'b0}.
  - A pop occurring in the same cycle is treated as accepted by execute; the flush still applies.
  - Fetch restarts at the next edge per the issue rule.
- run low:
  - No new issue; in-flight reads complete and are buffered; the FIFO keeps draining.
  - When run rises again, fetch resumes at the current pc.
- Halt: execute redirects to the halting instruction's address. The unit then refetches that address indefinitely; no special state is needed.

Test Plan:
- Basic fetch: RAM[0x100]=0x111C, RAM[0x102]=0x711A. Release reset, run=1, instr_ready=1 -> after E3, instr=0x111C with instr_pc=0x100; next cycle instr=0x711A with instr_pc=0x102. mem_addr steps 0x100, 0x102, 0x104… one per cycle.
- Backpressure: instr_ready=0 -> exactly 4 reads (0x100–0x106) are issued, then mem_rd_en stays 0 and count=4. Raise instr_ready -> 0x100, 0x102, 0x104, 0x106 are delivered in order with no loss or duplication, and fetching continues at 0x108.
- Redirect flush: mid-stream, pulse redirect_valid with redirect_pc=0x100 while a word for 0x11A is returning -> that word is never presented. The next instr_valid carries instr_pc=0x100, exactly 3 edges later.
- Odd redirect / wrap:
  - redirect_pc=0x117 -> the fetch address is 0x116.
  - RESET_PC='hFFE -> fetch order is 0xFFE, then 0x000.
- run gating: drop run for 5 cycles mid-stream -> at most 2 in-flight words are captured and mem_rd_en=0 throughout. On resume, addresses are contiguous.
- Async reset mid-operation: assert rst_n low between edges while count=3 -> instr_valid and mem_rd_en fall immediately. After release, the first fetch is RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, its instruction RAM and the execute stage.
// The master side belongs to the fetch unit; the slave side is the RAM/execute environment.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16
) ();

  logic                  run;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    input  run,
    input  mem_rdata,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_pc,
    output mem_addr,
    output mem_rd_en,
    output instr,
    output instr_pc,
    output instr_valid
  );

  modport slave (
    output run,
    output mem_rdata,
    output instr_ready,
    output redirect_valid,
    output redirect_pc,
    input  mem_addr,
    input  mem_rd_en,
    input  instr,
    input  instr_pc,
    input  instr_valid
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle-latency RAM reads and buffers
// returned words with their addresses in a small in-order FIFO toward execute.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'('h100),
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus_io
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  rd_en_q, rd_en_d;  // p0: request on the bus this cycle
  logic                  p1_q;              // data for tag1_q is on mem_rdata this cycle
  logic [ADDR_WIDTH-1:0] tag1_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  logic            pop;
  logic            push;
  logic            issue;
  logic [OccW-1:0] occ;

  // Credit check counts words already in flight so every returning word has a slot.
  always_comb begin
    pop   = (count_q != '0) & bus_io.instr_ready;
    push  = p1_q;
    occ   = OccW'(count_q) + OccW'(rd_en_q) + OccW'(p1_q) - OccW'(pop);
    issue = bus_io.run & (occ < OccW'(FIFO_DEPTH));

    rd_en_d    = issue;
    mem_addr_d = issue ? pc_q : mem_addr_q;
    pc_d       = issue ? pc_q + ADDR_WIDTH'(2) : pc_q;

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      rd_en_q    <= 1'b0;
      p1_q       <= 1'b0;
      tag1_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else if (bus_io.redirect_valid) begin
      // Flush wins over any pop/push this edge; the returning word is dropped.
      pc_q     <= {bus_io.redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      rd_en_q  <= 1'b0;
      p1_q     <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      rd_en_q    <= rd_en_d;
      p1_q       <= rd_en_q;
      tag1_q     <= mem_addr_q;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= bus_io.mem_rdata;
        fifo_pc_q[wr_ptr_q]   <= tag1_q;
      end
    end
  end

  assign bus_io.mem_addr    = mem_addr_q;
  assign bus_io.mem_rd_en   = rd_en_q;
  assign bus_io.instr       = fifo_data_q[rd_ptr_q];
  assign bus_io.instr_pc    = fifo_pc_q[rd_ptr_q];
  assign bus_io.instr_valid = (count_q != '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed sequences, a redirect vector table and a randomized
// run against a queue-based model of outstanding fetches.
module tb_instr_fetch_unit;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [DW-1:0] ram [4096];

  instr_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_fetch_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC  (12'h100),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  // Instruction RAM with a fixed one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct {
    logic [AW-1:0] rpc;
    logic [AW-1:0] exp_pc0;
    logic [AW-1:0] exp_pc1;
  } redir_vec_t;

  redir_vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input logic run_v, input logic ready_v);
    @(negedge clk);
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.run = run_v;
    bus.instr_ready = ready_v;
  endtask

  // Called at a negedge with run=1, ready=1; the redirect takes effect at the next edge R.
  task automatic redirect_seq(input logic [AW-1:0] rpc, input logic [AW-1:0] e0,
                              input logic [AW-1:0] e1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = rpc;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("redir_flush_valid", bus.instr_valid, 0);
    chk("redir_flush_rden", bus.mem_rd_en, 0);
    @(negedge clk);
    chk("redir_first_rden", bus.mem_rd_en, 1);
    chk("redir_first_addr", bus.mem_addr, e0);
    chk("redir_r1_valid", bus.instr_valid, 0);
    @(negedge clk);
    chk("redir_r2_valid", bus.instr_valid, 0);
    chk("redir_second_addr", bus.mem_addr, e1);
    @(negedge clk);
    chk("redir_r3_valid", bus.instr_valid, 1);
    chk("redir_r3_pc", bus.instr_pc, e0);
    chk("redir_r3_instr", bus.instr, ram[e0]);
    @(negedge clk);
    chk("redir_r4_pc", bus.instr_pc, e1);
    chk("redir_r4_instr", bus.instr, ram[e1]);
  endtask

  // Reference model state: one queue entry per issued, not yet consumed word.
  int            out_q[$];
  logic [AW-1:0] m_iss;
  logic [AW-1:0] m_del;
  logic          m_rd;

  task automatic model_step();
    logic exp_valid;
    logic redir;
    logic [AW-1:0] rpc;
    @(negedge clk);
    chk("rnd_rden", bus.mem_rd_en, m_rd);
    if (bus.mem_rd_en) begin
      chk("rnd_issue_addr", bus.mem_addr, m_iss);
      out_q.push_back(cyc);
      m_iss = m_iss + 12'd2;
    end
    exp_valid = (out_q.size() > 0) && (out_q[0] + 2 <= cyc);
    chk("rnd_valid", bus.instr_valid, exp_valid);
    bus.run = ($urandom_range(0, 3) != 0);
    bus.instr_ready = ($urandom_range(0, 2) != 0);
    redir = ($urandom_range(0, 24) == 0);
    rpc = AW'($urandom_range(0, 4095));
    bus.redirect_valid = redir;
    bus.redirect_pc = rpc;
    if (exp_valid && bus.instr_ready) begin
      chk("rnd_deliver_pc", bus.instr_pc, m_del);
      chk("rnd_deliver_instr", bus.instr, ram[m_del]);
      m_del = m_del + 12'd2;
      void'(out_q.pop_front());
    end
    if (redir) begin
      out_q.delete();
      m_iss = {rpc[AW-1:1], 1'b0};
      m_del = {rpc[AW-1:1], 1'b0};
      m_rd  = 1'b0;
    end else begin
      m_rd = bus.run && (out_q.size() < DEPTH);
    end
  endtask

  initial begin
    logic [AW-1:0] ex;
    logic [AW-1:0] ei;
    int issued;
    bit found;

    for (int i = 0; i < 4096; i++) ram[i] = DW'($urandom);
    ram[12'h100] = 16'h111C;
    ram[12'h102] = 16'h711A;

    vecs[0] = '{rpc: 12'h117, exp_pc0: 12'h116, exp_pc1: 12'h118};
    vecs[1] = '{rpc: 12'hFFF, exp_pc0: 12'hFFE, exp_pc1: 12'h000};
    vecs[2] = '{rpc: 12'h100, exp_pc0: 12'h100, exp_pc1: 12'h102};
    vecs[3] = '{rpc: 12'h001, exp_pc0: 12'h000, exp_pc1: 12'h002};
    vecs[4] = '{rpc: 12'hABD, exp_pc0: 12'hABC, exp_pc1: 12'hABE};

    bus.run = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_addr", bus.mem_addr, 12'h100);
    chk("rst_rden", bus.mem_rd_en, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);

    // Basic fetch
    rst_n = 1'b1;
    bus.run = 1'b1;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("basic_e1_rden", bus.mem_rd_en, 1);
    chk("basic_e1_addr", bus.mem_addr, 12'h100);
    chk("basic_e1_valid", bus.instr_valid, 0);
    @(negedge clk);
    chk("basic_e2_addr", bus.mem_addr, 12'h102);
    chk("basic_e2_valid", bus.instr_valid, 0);
    @(negedge clk);
    chk("basic_e3_valid", bus.instr_valid, 1);
    chk("basic_e3_instr", bus.instr, 16'h111C);
    chk("basic_e3_pc", bus.instr_pc, 12'h100);
    chk("basic_e3_addr", bus.mem_addr, 12'h104);
    @(negedge clk);
    chk("basic_e4_instr", bus.instr, 16'h711A);
    chk("basic_e4_pc", bus.instr_pc, 12'h102);

    // Backpressure: exactly DEPTH reads, then in-order drain continuing at 0x108
    do_reset(1'b1, 1'b0);
    issued = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin
        chk("bp_issue_addr", bus.mem_addr, 12'h100 + 12'(2 * issued));
        issued++;
      end
    end
    chk("bp_issue_count", issued, DEPTH);
    chk("bp_hold_valid", bus.instr_valid, 1);
    chk("bp_hold_pc", bus.instr_pc, 12'h100);
    bus.instr_ready = 1'b1;
    ex = 12'h100;
    for (int i = 0; i < 16 && ex != 12'h10A; i++) begin
      if (bus.instr_valid) begin
        chk("bp_drain_pc", bus.instr_pc, ex);
        chk("bp_drain_instr", bus.instr, ram[ex]);
        ex = ex + 12'd2;
      end
      @(negedge clk);
    end
    chk("bp_drain_done", ex, 12'h10A);

    // Redirect while the 0x11A word is returning
    do_reset(1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mem_rd_en && bus.mem_addr == 12'h11C) begin
        found = 1'b1;
        break;
      end
    end
    chk("flush_reach_11c", found, 1);
    redirect_seq(12'h100, 12'h100, 12'h102);

    // Redirect vector table (odd targets, wrap)
    for (int v = 0; v < 5; v++) begin
      redirect_seq(vecs[v].rpc, vecs[v].exp_pc0, vecs[v].exp_pc1);
      @(negedge clk);
    end

    // run gating: run low for 5 edges mid-stream, addresses stay contiguous
    do_reset(1'b1, 1'b1);
    ex = 12'h100;
    ei = 12'h100;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin
        chk("run_issue_addr", bus.mem_addr, ei);
        ei = ei + 12'd2;
      end
      if (i >= 11 && i <= 15) chk("run_low_rden", bus.mem_rd_en, 0);
      if (bus.instr_valid) begin
        chk("run_deliver_pc", bus.instr_pc, ex);
        ex = ex + 12'd2;
      end
      bus.run = !(i >= 10 && i < 15);
    end
    chk("run_progress", (ex >= 12'h124), 1);

    // Async reset between edges while count=3
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("arst_pre_valid", bus.instr_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.instr_valid, 0);
    chk("arst_rden", bus.mem_rd_en, 0);
    chk("arst_addr", bus.mem_addr, 12'h100);

    // Async reset while streaming with a request on the bus
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("arst2_pre_rden", bus.mem_rd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_rden", bus.mem_rd_en, 0);
    chk("arst2_valid", bus.instr_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst2_first_rden", bus.mem_rd_en, 1);
    chk("arst2_first_addr", bus.mem_addr, 12'h100);

    // Randomized run against the outstanding-fetch model
    do_reset(1'b0, 1'b0);
    out_q.delete();
    m_iss = 12'h100;
    m_del = 12'h100;
    m_rd  = 1'b0;
    for (int i = 0; i < 1500; i++) model_step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
